// File: rtl/calc_pkg.sv
// Shared definitions for the calc sequencer: widths, FSM encoding and ALU opcodes.
package calc_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CTRL_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Opcodes understood by the external ALU; 1101-1111 are passed through untouched.
  localparam logic [CTRL_W-1:0] OP_ADD = 4'b0000;
  localparam logic [CTRL_W-1:0] OP_SUB = 4'b0001;
  localparam logic [CTRL_W-1:0] OP_AND = 4'b0010;
  localparam logic [CTRL_W-1:0] OP_OR  = 4'b0011;
  localparam logic [CTRL_W-1:0] OP_XOR = 4'b0100;
  localparam logic [CTRL_W-1:0] OP_NOT = 4'b0101;
  localparam logic [CTRL_W-1:0] OP_SHL = 4'b0110;
  localparam logic [CTRL_W-1:0] OP_SHR = 4'b0111;
  localparam logic [CTRL_W-1:0] OP_ROL = 4'b1000;
  localparam logic [CTRL_W-1:0] OP_ROR = 4'b1001;
  localparam logic [CTRL_W-1:0] OP_INC = 4'b1010;
  localparam logic [CTRL_W-1:0] OP_DEC = 4'b1011;
  localparam logic [CTRL_W-1:0] OP_EQ  = 4'b1100;

endpackage

// File: rtl/calc_regfile.sv
// 8x8 register file: two combinational read ports, one synchronous write port, r0 reads zero.
module calc_regfile
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr_x,
  input  logic [ADDR_W-1:0] raddr_y,
  output logic [DATA_W-1:0] rdata_x,
  output logic [DATA_W-1:0] rdata_y,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Reset wins over a same-edge write so an aborted instruction leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_x = (raddr_x == '0) ? '0 : regs[raddr_x];
  assign rdata_y = (raddr_y == '0) ? '0 : regs[raddr_y];

endmodule

// File: rtl/calc_sequencer.sv
// Single-issue instruction sequencer: register file read, external ALU execute, write-back, response.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic [3:0]  in_ctrl,
  input  logic [2:0]  in_rx,
  input  logic [2:0]  in_ry,
  input  logic [2:0]  in_rw,
  input  logic [7:0]  in_imm,
  output logic [3:0]  alu_ctrl,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_carry,
  output logic [7:0]  op_count,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // The producer holds valid and its payload until that edge; ready never depends on valid.

  state_t state, next_state;

  logic [CTRL_W-1:0] ctrl_q;
  logic [ADDR_W-1:0] rx_q, ry_q, rw_q;
  logic [DATA_W-1:0] opx_q, opy_q, result_q;
  logic              carry_q;
  logic [7:0]        op_count_q;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rd_x, rd_y;

  calc_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_x (rx_q),
    .raddr_y (ry_q),
    .rdata_x (rd_x),
    .rdata_y (rd_y),
    .we      (rf_we & ~rst),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    rf_we      = 1'b0;
    rf_waddr   = rw_q;
    rf_wdata   = alu_out;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_load) begin
            next_state = ST_RESP;
            rf_we      = 1'b1;
            rf_waddr   = in_rw;
            rf_wdata   = in_imm;
          end else begin
            next_state = ST_READ;
          end
        end
      end
      ST_READ: next_state = ST_EXEC;
      ST_EXEC: begin
        next_state = ST_RESP;
        rf_we      = 1'b1;
      end
      ST_RESP: begin
        if (out_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      rw_q       <= '0;
      opx_q      <= '0;
      opy_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      op_count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_load) begin
              result_q <= in_imm;
              carry_q  <= 1'b0;
            end else begin
              ctrl_q <= in_ctrl;
              rx_q   <= in_rx;
              ry_q   <= in_ry;
              rw_q   <= in_rw;
            end
          end
        end
        ST_READ: begin
          opx_q <= rd_x;
          opy_q <= rd_y;
        end
        ST_EXEC: begin
          result_q <= alu_out;
          carry_q  <= alu_carry;
        end
        ST_RESP: begin
          if (out_ready) begin
            op_count_q <= op_count_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);
  assign out_data  = result_q;
  assign out_carry = carry_q;
  assign alu_ctrl  = ctrl_q;
  assign alu_x     = opx_q;
  assign alu_y     = opy_q;
  assign op_count  = op_count_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small behavioural ALU on the alu_* ports.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_load = 1'b0;
  logic [3:0] in_ctrl = '0;
  logic [2:0] in_rx = '0, in_ry = '0, in_rw = '0;
  logic [7:0] in_imm = '0;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y, alu_out;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_carry;
  logic [7:0] op_count;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_count = 8'h00;
  logic [7:0] got_d;
  logic       got_c;

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_ctrl(in_ctrl),
    .in_rx(in_rx), .in_ry(in_ry), .in_rw(in_rw), .in_imm(in_imm),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // Behavioural ALU: unimplemented opcodes return zero with no carry.
  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    case (alu_ctrl)
      4'b0000: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
      4'b0001: {alu_carry, alu_out} = {1'b0, alu_x} - {1'b0, alu_y};
      4'b0010: alu_out = alu_x & alu_y;
      4'b0011: alu_out = alu_x | alu_y;
      4'b0100: alu_out = alu_x ^ alu_y;
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and return #1 after its accept edge.
  task automatic issue(input logic ld, input logic [3:0] c, input logic [2:0] x,
                       input logic [2:0] y, input logic [2:0] w, input logic [7:0] imm);
    bit done = 0;
    in_load = ld; in_ctrl = c; in_rx = x; in_ry = y; in_rw = w; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      step();
    end
    in_valid = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic wait_resp();
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) seen = 1;
      else step();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL resp_timeout: out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic run_op(input logic ld, input logic [3:0] c, input logic [2:0] x,
                        input logic [2:0] y, input logic [2:0] w, input logic [7:0] imm,
                        output logic [7:0] d, output logic cy);
    issue(ld, c, x, y, w, imm);
    wait_resp();
    d = out_data;
    cy = out_carry;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_count++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    total += 8;
    if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready: got=%0b exp=1", in_ready); end
    if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid: got=%0b exp=0", out_valid); end
    if (out_data !== 8'h00)  begin bad++; $display("FAIL reset_out_data: got=%h exp=00", out_data); end
    if (out_carry !== 1'b0)  begin bad++; $display("FAIL reset_out_carry: got=%0b exp=0", out_carry); end
    if (alu_ctrl !== 4'h0)   begin bad++; $display("FAIL reset_alu_ctrl: got=%h exp=0", alu_ctrl); end
    if (alu_x !== 8'h00)     begin bad++; $display("FAIL reset_alu_x: got=%h exp=00", alu_x); end
    if (alu_y !== 8'h00)     begin bad++; $display("FAIL reset_alu_y: got=%h exp=00", alu_y); end
    if (op_count !== 8'h00)  begin bad++; $display("FAIL reset_op_count: got=%h exp=00", op_count); end
  endtask

  task automatic test_load_add();
    run_op(1, 4'h0, 0, 0, 1, 8'h0F, got_d, got_c);
    total++; if (got_d !== 8'h0F) begin bad++; $display("FAIL load_r1: got=%h exp=0f", got_d); end
    run_op(1, 4'h0, 0, 0, 2, 8'h01, got_d, got_c);
    run_op(0, 4'h0, 1, 2, 3, 8'h00, got_d, got_c);
    total += 3;
    if (got_d !== 8'h10) begin bad++; $display("FAIL add_data: got=%h exp=10", got_d); end
    if (got_c !== 1'b0)  begin bad++; $display("FAIL add_carry: got=%0b exp=0", got_c); end
    if (op_count !== 8'd3) begin bad++; $display("FAIL add_op_count: got=%0d exp=3", op_count); end
    run_op(0, 4'h3, 3, 0, 5, 8'h00, got_d, got_c);
    total++; if (got_d !== 8'h10) begin bad++; $display("FAIL read_r3: got=%h exp=10", got_d); end
  endtask

  task automatic test_latency();
    issue(0, 4'h0, 1, 2, 6, 8'h00);
    // Junk load offered while busy must be ignored.
    in_valid = 1'b1; in_load = 1'b1; in_rw = 3'd7; in_imm = 8'hEE;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_read_valid: got=%0b exp=0", out_valid); end
    if (alu_ctrl !== 4'h0)  begin bad++; $display("FAIL lat_read_ctrl: got=%h exp=0", alu_ctrl); end
    step();
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_exec_valid: got=%0b exp=0", out_valid); end
    if (alu_x !== 8'h0F)    begin bad++; $display("FAIL lat_exec_x: got=%h exp=0f", alu_x); end
    if (alu_y !== 8'h01)    begin bad++; $display("FAIL lat_exec_y: got=%h exp=01", alu_y); end
    step();
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_resp_valid: got=%0b exp=1", out_valid); end
    if (out_data !== 8'h10) begin bad++; $display("FAIL lat_resp_data: got=%h exp=10", out_data); end
    if (alu_x !== 8'h0F)    begin bad++; $display("FAIL lat_resp_x_held: got=%h exp=0f", alu_x); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    exp_count++;
    run_op(0, 4'h3, 7, 0, 5, 8'h00, got_d, got_c);
    total++; if (got_d !== 8'h00) begin bad++; $display("FAIL ignored_load_r7: got=%h exp=00", got_d); end
  endtask

  task automatic test_hold();
    issue(1, 4'h0, 0, 0, 5, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got=%0b exp=1", i, out_valid); end
      if (out_data !== 8'h5A) begin bad++; $display("FAIL hold_data[%0d]: got=%h exp=5a", i, out_data); end
      if (op_count !== exp_count) begin bad++; $display("FAIL hold_count[%0d]: got=%0d exp=%0d", i, op_count, exp_count); end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_count++;
    total += 2;
    if (op_count !== exp_count) begin bad++; $display("FAIL hold_count_after: got=%0d exp=%0d", op_count, exp_count); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_valid_after: got=%0b exp=0", out_valid); end
  endtask

  task automatic test_r0();
    run_op(1, 4'h0, 0, 0, 0, 8'hAA, got_d, got_c);
    total++; if (got_d !== 8'hAA) begin bad++; $display("FAIL load_r0_data: got=%h exp=aa", got_d); end
    issue(0, 4'h2, 0, 1, 2, 8'h00);
    step();
    total += 3;
    if (alu_x !== 8'h00)   begin bad++; $display("FAIL r0_alu_x: got=%h exp=00", alu_x); end
    if (alu_y !== 8'h0F)   begin bad++; $display("FAIL r0_alu_y: got=%h exp=0f", alu_y); end
    if (alu_ctrl !== 4'h2) begin bad++; $display("FAIL r0_alu_ctrl: got=%h exp=2", alu_ctrl); end
    wait_resp();
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL r0_and_data: got=%h exp=00", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_count++;
  endtask

  task automatic test_back_to_back();
    in_load = 0; in_ctrl = 4'h0; in_rx = 1; in_ry = 1; in_rw = 2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0: got=%0b exp=1", in_ready); end
    step();
    in_rx = 2; in_ry = 2; in_rw = 2;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_read: got=%0b exp=0", in_ready); end
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_exec: got=%0b exp=0", in_ready); end
    step();
    total += 3;
    if (in_ready !== 1'b0)  begin bad++; $display("FAIL b2b_ready_resp: got=%0b exp=0", in_ready); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid1: got=%0b exp=1", out_valid); end
    if (out_data !== 8'h1E) begin bad++; $display("FAIL b2b_data1: got=%h exp=1e", out_data); end
    step();
    exp_count++;
    total += 2;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_idle: got=%0b exp=1", in_ready); end
    if (op_count !== exp_count) begin bad++; $display("FAIL b2b_count1: got=%0d exp=%0d", op_count, exp_count); end
    step();
    in_valid = 1'b0;
    step();
    total++; if (alu_x !== 8'h1E) begin bad++; $display("FAIL b2b_operand: got=%h exp=1e", alu_x); end
    step();
    total++; if (out_data !== 8'h3C) begin bad++; $display("FAIL b2b_data2: got=%h exp=3c", out_data); end
    step();
    out_ready = 1'b0;
    exp_count++;
    total++; if (op_count !== exp_count) begin bad++; $display("FAIL b2b_count2: got=%0d exp=%0d", op_count, exp_count); end
  endtask

  task automatic test_reset_abort();
    issue(0, 4'h1, 1, 3, 4, 8'h00);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 8'h00;
    total += 6;
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL abort_in_ready: got=%0b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid: got=%0b exp=0", out_valid); end
    if (out_data !== 8'h00) begin bad++; $display("FAIL abort_out_data: got=%h exp=00", out_data); end
    if (alu_ctrl !== 4'h0)  begin bad++; $display("FAIL abort_alu_ctrl: got=%h exp=0", alu_ctrl); end
    if ({alu_x, alu_y} !== 16'h0000) begin bad++; $display("FAIL abort_alu_xy: got=%h exp=0000", {alu_x, alu_y}); end
    if (op_count !== 8'h00) begin bad++; $display("FAIL abort_op_count: got=%h exp=00", op_count); end
    run_op(0, 4'h3, 4, 0, 5, 8'h00, got_d, got_c);
    total++; if (got_d !== 8'h00) begin bad++; $display("FAIL abort_r4: got=%h exp=00", got_d); end
    run_op(0, 4'h3, 1, 0, 5, 8'h00, got_d, got_c);
    total++; if (got_d !== 8'h00) begin bad++; $display("FAIL abort_r1_cleared: got=%h exp=00", got_d); end
  endtask

  task automatic test_undef_op();
    run_op(1, 4'h0, 0, 0, 1, 8'h33, got_d, got_c);
    run_op(1, 4'h0, 0, 0, 2, 8'h44, got_d, got_c);
    run_op(1, 4'h0, 0, 0, 3, 8'h77, got_d, got_c);
    run_op(0, 4'hE, 1, 2, 3, 8'h00, got_d, got_c);
    total += 2;
    if (got_d !== 8'h00) begin bad++; $display("FAIL op_e_data: got=%h exp=00", got_d); end
    if (got_c !== 1'b0)  begin bad++; $display("FAIL op_e_carry: got=%0b exp=0", got_c); end
    run_op(0, 4'h3, 3, 1, 4, 8'h00, got_d, got_c);
    total++; if (got_d !== 8'h33) begin bad++; $display("FAIL op_e_writeback: got=%h exp=33", got_d); end
    run_op(0, 4'hD, 1, 2, 5, 8'h00, got_d, got_c);
    total++; if (got_d !== 8'h00) begin bad++; $display("FAIL op_d_data: got=%h exp=00", got_d); end
    run_op(0, 4'hF, 1, 2, 5, 8'h00, got_d, got_c);
    total++; if (got_d !== 8'h00) begin bad++; $display("FAIL op_f_data: got=%h exp=00", got_d); end
    run_op(0, 4'h1, 3, 1, 6, 8'h00, got_d, got_c);
    total += 2;
    if (got_d !== 8'hCD) begin bad++; $display("FAIL sub_borrow_data: got=%h exp=cd", got_d); end
    if (got_c !== 1'b1)  begin bad++; $display("FAIL sub_borrow_carry: got=%0b exp=1", got_c); end
  endtask

  task automatic test_wrap();
    while (exp_count != 8'hFF) begin
      run_op(1, 4'h0, 0, 0, 6, exp_count, got_d, got_c);
    end
    total++; if (op_count !== 8'hFF) begin bad++; $display("FAIL wrap_ff: got=%h exp=ff", op_count); end
    run_op(1, 4'h0, 0, 0, 6, 8'h01, got_d, got_c);
    total++; if (op_count !== 8'h00) begin bad++; $display("FAIL wrap_00: got=%h exp=00", op_count); end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_latency();
    test_hold();
    test_r0();
    test_back_to_back();
    test_reset_abort();
    test_undef_op();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The clock port SHALL be `clk`, input, 1 bit, and all state SHALL update on its rising edge.
REQ-002 The reset port SHALL be `rst`, input, 1 bit; reset SHALL be synchronous and active-high.
REQ-003 `in_valid` SHALL be an input, 1 bit, meaning an instruction is offered.
REQ-004 `in_ready` SHALL be an output, 1 bit, meaning the block can accept an instruction.
REQ-005 `in_load` SHALL be an input, 1 bit: 1 means load the immediate, 0 means an ALU operation.
REQ-006 `in_ctrl` SHALL be an input, 4 bits, carrying the ALU opcode.
REQ-007 `in_rx`, `in_ry` and `in_rw` SHALL each be inputs, 3 bits, giving the source X, source Y and destination register indices.
REQ-008 `in_imm` SHALL be an input, 8 bits, carrying the load immediate.
REQ-009 `alu_ctrl` (4 bits), `alu_x` (8 bits) and `alu_y` (8 bits) SHALL be outputs that drive the downstream ALU.
REQ-010 `alu_out` (8 bits) and `alu_carry` (1 bit) SHALL be inputs that return the ALU result and carry.
REQ-011 `out_valid` SHALL be an output, 1 bit, meaning a result is presented.
REQ-012 `out_ready` SHALL be an input, 1 bit, meaning the consumer accepts the result.
REQ-013 `out_data` (8 bits) and `out_carry` (1 bit) SHALL be outputs carrying the result and its carry.
REQ-014 `op_count` SHALL be an output, 8 bits, counting completed transactions.

Function
REQ-015 The block SHALL contain an 8x8 register file; r0 SHALL read 0 always, and writes to r0 SHALL be discarded.
REQ-016 The FSM SHALL have states IDLE, READ, EXEC and RESP, and `in_ready` SHALL be 1 only in IDLE.
REQ-017 In IDLE with `in_valid` = 1 and `in_load` = 0, the block SHALL latch ctrl/rx/ry/rw and move to READ.
REQ-018 In IDLE with `in_valid` = 1 and `in_load` = 1, on the same edge the block SHALL write `in_imm` to rf[rw], set result = imm and carry = 0, and move to RESP.
REQ-019 On leaving READ, the block SHALL register opx = rf[rx] and opy = rf[ry], then move to EXEC.
REQ-020 `alu_ctrl`, `alu_x` and `alu_y` SHALL be driven from the latched ctrl, opx and opy registers, and SHALL be held stable from READ through RESP.
REQ-021 On leaving EXEC, the block SHALL capture `alu_out` and `alu_carry` into the result registers, write the result to rf[rw], and move to RESP.
REQ-022 In RESP, `out_valid` SHALL be 1 and `out_data`/`out_carry` SHALL equal the result registers, held stable while `out_ready` = 0.
REQ-023 In RESP with `out_ready` = 1, the block SHALL increment `op_count` (mod 256) and return to IDLE.
REQ-024 Latency for an ALU op SHALL be `out_valid` asserting after the 2nd rising edge following the accept edge; for a load, immediately after the accept edge.
REQ-025 Throughput SHALL be at most one instruction per 4 cycles for an ALU op and per 2 cycles for a load, and the block SHALL NOT pipeline instructions.
REQ-026 A following instruction SHALL read register values that include the previous instruction's write-back, with no forwarding needed.
REQ-027 Opcodes 1101–1111 SHALL execute normally; whatever the ALU returns SHALL be written back.
REQ-028 `in_valid` SHALL be ignored outside IDLE, and instruction fields SHALL be sampled only on the accept edge.
REQ-029 `op_count` SHALL wrap from 0xFF to 0x00.

Reset
REQ-030 While `rst` = 1 at a rising edge, the FSM SHALL go to IDLE and all registers r1–r7 SHALL clear to 0.
REQ-031 Reset SHALL clear opx, opy, latched ctrl/rx/ry/rw, result, carry and `op_count` to 0.
REQ-032 After reset, the outputs SHALL be `in_ready` = 1, `out_valid` = 0, `out_data` = 0x00, `out_carry` = 0, `alu_ctrl` = 0, `alu_x` = 0, `alu_y` = 0 and `op_count` = 0.
REQ-033 Reset asserted mid-transaction SHALL abort it; if that edge would also have been a write-back edge, reset SHALL take priority and the write SHALL NOT occur.

Structure
REQ-034 Package `calc_pkg` SHALL hold the FSM state encoding, the opcode localparams (0000 ADD … 1100 EQ), and the data width (8) and register-address width (3).
REQ-035 The register file SHALL be a sub-module `calc_regfile` with 2 combinational read ports, 1 synchronous write port and r0 hardwired to zero.
REQ-036 The ALU SHALL remain external and SHALL connect only through the alu_* ports.

Verification
REQ-037 Scenario: load r1 = 0x0F, load r2 = 0x01, then ADD (0000) x = r1, y = r2, rw = 3 → `out_data` = 0x10, a later op reads r3 = 0x10, and `op_count` = 3.
REQ-038 Scenario: hold `out_ready` = 0 for 3 cycles in RESP with result 0x5A → `out_valid` = 1 and `out_data` = 0x5A on every cycle, and `op_count` increments only on the handshake.
REQ-039 Scenario: load r0 = 0xAA → `out_data` = 0xAA, and a subsequent AND with rx = 0 gives `alu_x` = 0x00.
REQ-040 Scenario: back-to-back instructions with `in_valid` held at 1 → the 2nd is accepted only when `in_ready` = 1 after RESP completes, and the 2nd operand read sees the 1st result.
REQ-041 Scenario: assert `rst` in EXEC of a SUB with rw = 4 → r4 is unchanged (0), and the outputs match the REQ-032 reset values on the next cycle.
REQ-042 Scenario: in a bench with the ALU model connected, opcode 1110 with any operands → `out_data` = 0x00, `out_carry` = 0, and rf[rw] = 0x00.
